wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the ALU result or the loaded data, and commits the value to the 32×32 register file. It also serves the two decode-stage read ports with same-cycle write bypass and keeps a committed-write counter for debug and verification.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clock  in  1  sole clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- wwreg  in  1  writeback enable from MEM/WB
- wm2reg  in  1  1 = write load data (wdo), 0 = write ALU result (wr)
- wdestReg  in  ADDR_W  destination register index
- wr  in  DATA_W  ALU result
- wdo  in  DATA_W  data-memory load result
- rs  in  ADDR_W  read port A index (decode stage)
- rt  in  ADDR_W  read port B index (decode stage)
- qa  out  DATA_W  read port A data
- qb  out  DATA_W  read port B data
- wdata  out  DATA_W  selected writeback value, for the forwarding unit
- commit_count  out  32  number of committed register writes

The design has one clock. Reset is asynchronous and active-high.

## Operation
- wdata = wm2reg ? wdo : wr. This is combinational and always driven, regardless of wwreg.
- The write is effective when wwreg = 1 and wdestReg != 0. On the rising clock edge, regs[wdestReg] <= wdata.
- Register 0 is hardwired to zero. A write to r0 is discarded and is not counted.
- Reads are combinational. For port A:
  - if rs == 0, qa = 0;
  - else if a write is effective this cycle and rs == wdestReg, qa = wdata (bypass);
  - else qa = regs[rs].
- Port B is identical to port A, using rt and qb.
- When both ports address the same register, both return the same value, bypass included.
- commit_count increments by 1 on every clock edge where a write is effective. It wraps from 0xFFFF_FFFF to 0 with no flag.
- No write of X or undefined data is filtered. Whatever wdata is gets stored.

## Timing
- Reset values: regs[1..31] = 0 and commit_count = 0. qa, qb and wdata follow their combinational definitions, so with zeroed registers qa and qb read 0 unless a bypass hit occurs.
- Write latency is 1 cycle. The value is visible through regs from the cycle after the edge. Within the write cycle it is visible through the bypass.
- The bypass reproduces the classic "write first half, read second half" behaviour. Decode reading a register being written back in the same cycle sees the new value, with no extra stall.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. A write coinciding with a clock edge while reset is high is dropped, and the counter stays 0.
- Reset deasserting concurrently with a clock edge is treated as a reset-held edge, so no write occurs on that edge.
- Back-to-back writes to the same register: each edge overwrites in order. The counter counts both.

## Structure
- The shared package mips_pkg holds DATA_W and ADDR_W defaults, the REG_ZERO constant (5'd0), and the NUM_REGS constant (32). The pipeline register modules and the hazard unit import the same constants.
- The sub-module regfile_core holds the storage array, the asynchronous reset, the single write port with r0 suppression, and two raw read ports.
- wb_regfile instantiates regfile_core and adds the writeback mux, the bypass logic, and commit_count.

## Test plan
- Reset test: assert reset, then read all 32 indices on rs/rt. Required: every read is 0 and commit_count = 0.
- Write/read test: write wwreg = 1, wm2reg = 0, wdestReg = 5, wr = 0xDEADBEEF, then read rs = 5 on the next cycle. Required: qa = 0xDEADBEEF and commit_count = 1.
- Load path with same-cycle bypass: drive wm2reg = 1, wdo = 0x1234_5678, wdestReg = 9, with rs = rt = 9 in the same cycle. Required: qa = qb = 0x12345678 before the edge, and the values persist after the edge.
- r0 protection: write wdestReg = 0 with wr = 0xFFFFFFFF. Required: qa at rs = 0 reads 0, there is no bypass, and commit_count is unchanged.
- Disabled write: hold wwreg = 0 with wdestReg = 3 and wr = 0xAAAA_AAAA. Required: r3 is unchanged, and wdata still shows 0xAAAAAAAA.
- Asynchronous reset mid-stream: after writes to r1–r4, assert reset between edges. Required: all registers and commit_count read 0 immediately, and a write presented on the edge during reset is not stored.
- Counter wrap: preload commit_count to 0xFFFFFFFF by force, then perform one effective write. Required: commit_count = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS pipeline datapath.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_core.sv
// Architectural register storage: one write port, two raw read ports.
// r0 is never written and always reads as zero.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];

  // Storage update: async clear, writes to r0 dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ZERO_IDX)) begin
      regs[waddr] <= wdata;
    end
  end

  // Raw read ports; r0 forced to zero regardless of storage contents.
  always_comb begin
    rdata_a = (raddr_a == ZERO_IDX) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == ZERO_IDX) ? '0 : regs[raddr_b];
  end

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/load value, commits it to the register file,
// bypasses it to the decode read ports in the same cycle, counts commits.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [ADDR_W-1:0] wdestReg,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wdo,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wdata,
  output logic [31:0]       commit_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              wr_eff;
  logic [DATA_W-1:0] raw_a;
  logic [DATA_W-1:0] raw_b;
  logic [31:0]       count_q;

  // Writeback mux and effective-write qualifier. A write seen while reset is
  // high never lands, so it must not be bypassed either.
  always_comb begin
    wdata  = wm2reg ? wdo : wr;
    wr_eff = wwreg && (wdestReg != ZERO_IDX) && !reset;
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .we      (wr_eff),
    .waddr   (wdestReg),
    .wdata   (wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  // Read ports with same-cycle write bypass (write-first-half behaviour).
  always_comb begin
    qa = raw_a;
    qb = raw_b;
    if (wr_eff && (rs == wdestReg) && (rs != ZERO_IDX)) begin
      qa = wdata;
    end
    if (wr_eff && (rt == wdestReg) && (rt != ZERO_IDX)) begin
      qb = wdata;
    end
  end

  // Committed-write counter; wraps silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (wr_eff) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign commit_count = count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expectations derived from
// an array model; a negedge monitor pops and compares.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic        wwreg;
  logic        wm2reg;
  logic [4:0]  wdestReg;
  logic [31:0] wr;
  logic [31:0] wdo;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] wdata;
  logic [31:0] commit_count;

  wb_regfile dut (
    .clock        (clock),
    .reset        (reset),
    .wwreg        (wwreg),
    .wm2reg       (wm2reg),
    .wdestReg     (wdestReg),
    .wr           (wr),
    .wdo          (wdo),
    .rs           (rs),
    .rt           (rt),
    .qa           (qa),
    .qb           (qb),
    .wdata        (wdata),
    .commit_count (commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] wdata;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: compare whatever expectation is pending against the DUT.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".qa"}, qa, e.qa);
      check({e.name, ".qb"}, qb, e.qb);
      check({e.name, ".wdata"}, wdata, e.wdata);
      check({e.name, ".count"}, commit_count, e.count);
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic eff,
                                             input logic [4:0] dest, input logic [31:0] val);
    if (idx == 5'd0) return 32'd0;
    if (eff && idx == dest) return val;
    return mregs[idx];
  endfunction

  // One cycle: drive inputs just after a rising edge, push expectation,
  // wait for the next edge, then advance the model.
  task automatic step(input string name, input logic rst, input logic ww, input logic m2,
                      input logic [4:0] dest, input logic [31:0] a_wr, input logic [31:0] a_wdo,
                      input logic [4:0] a_rs, input logic [4:0] a_rt);
    exp_t e;
    logic [31:0] val;
    logic eff;
    reset = rst; wwreg = ww; wm2reg = m2; wdestReg = dest;
    wr = a_wr; wdo = a_wdo; rs = a_rs; rt = a_rt;
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      mcount = 32'd0;
    end
    val = m2 ? a_wdo : a_wr;
    eff = ww && (dest != 5'd0) && !rst;
    e.name  = name;
    e.wdata = val;
    e.qa    = model_read(a_rs, eff, dest, val);
    e.qb    = model_read(a_rt, eff, dest, val);
    e.count = mcount;
    exp_q.push_back(e);
    @(posedge clock);
    if (eff) begin
      mregs[dest] = val;
      mcount = mcount + 32'd1;
    end
    #1;
  endtask

  initial begin
    int budget;
    foreach (mregs[i]) mregs[i] = 32'd0;
    mcount = 32'd0;
    reset = 1'b1; wwreg = 1'b0; wm2reg = 1'b0; wdestReg = '0;
    wr = '0; wdo = '0; rs = '0; rt = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state: all 32 indices over both ports.
    for (int i = 0; i < 16; i++)
      step("reset_rd", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(i + 16));

    step("wr5", 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0);
    step("rd5", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);

    step("ld9_bypass", 1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h12345678, 5'd9, 5'd9);
    step("ld9_after", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);

    step("r0_write", 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    step("r0_after", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd5);

    step("dis_wr3", 1'b0, 1'b0, 1'b0, 5'd3, 32'hAAAAAAAA, 32'h0, 5'd3, 5'd3);
    step("dis_rd3", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd9);

    for (int i = 1; i <= 4; i++)
      step("pre_rst_wr", 1'b0, 1'b1, 1'b0, 5'(i), 32'h100 + 32'(i), 32'h0, 5'(i), 5'd5);
    step("mid_rst_a", 1'b1, 1'b1, 1'b0, 5'd7, 32'h77777777, 32'h0, 5'd1, 5'd2);
    step("mid_rst_b", 1'b1, 1'b1, 1'b0, 5'd8, 32'h88888888, 32'h0, 5'd3, 5'd4);
    step("post_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd8);

    // Randomized traffic, reads biased toward the destination register.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] d, a, b;
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
           $urandom, $urandom, a, b);
    end

    // Counter wrap.
    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    mcount = 32'hFFFFFFFF;
    step("wrap_wr", 1'b0, 1'b1, 1'b0, 5'd12, 32'h0BADF00D, 32'h0, 5'd12, 5'd0);
    step("wrap_after", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd12);

    budget = 0;
    while (exp_q.size() > 0 && budget < 5) begin
      @(posedge clock);
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wb_regfile
